// File: rtl/prng_xoshiro_arbiter.sv
// Purpose : owns one xoshiro128++ core. It sequences seeding, jump() and long_jump(),
//           and shares the core's 32-bit output between N_REQ requesters in round-robin order.
// Latency : a request sampled in cycle t is acked with its data in t+1. A jump occupies
//           129 cycles (o_busy high).
// Backpr. : requests are level-held until acked. Outside READY they stay pending and are
//           not served. A requester is masked in the cycle its ack is visible.
// Ports   : i_clk/i_rst (async, active-low); i_seedValid/i_seed load a seed;
//           i_jump/i_jumpLong start a jump; i_req/o_ack/o_data form the per-requester word
//           handout; o_seeded and o_busy report controller status.

// xoshiro128++ state machine. Its state has no reset, so the controller must seed it.
// While i_cg is high, a seed load takes priority over a step.
module prngXoshiro128pp (
   input  logic         i_clk,
   input  logic         i_cg,
   input  logic         i_seedValid,
   input  logic [127:0] i_seed,
   output logic [31:0]  o_result,
   output logic [31:0]  o_s0,
   output logic [31:0]  o_s1,
   output logic [31:0]  o_s2,
   output logic [31:0]  o_s3
);
   logic [31:0] s0_q, s1_q, s2_q, s3_q;
   logic [31:0] sum, t, n0, n1, n2, n3, m2, m3;

   always_comb begin
      sum      = s0_q + s3_q;
      o_result = {sum[24:0], sum[31:25]} + s0_q;
      t        = s1_q << 9;
      m2       = s2_q ^ s0_q;
      m3       = s3_q ^ s1_q;
      n1       = s1_q ^ m2;
      n0       = s0_q ^ m3;
      n2       = m2 ^ t;
      n3       = {m3[20:0], m3[31:21]};
   end

   always_ff @(posedge i_clk) begin
      if (i_cg) begin
         if (i_seedValid) begin
            {s3_q, s2_q, s1_q, s0_q} <= i_seed;
         end else begin
            s0_q <= n0;
            s1_q <= n1;
            s2_q <= n2;
            s3_q <= n3;
         end
      end
   end

   assign o_s0 = s0_q;
   assign o_s1 = s1_q;
   assign o_s2 = s2_q;
   assign o_s3 = s3_q;
endmodule

module prng_xoshiro_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_seedValid,
   input  logic [127:0]     i_seed,
   input  logic             i_jump,
   input  logic             i_jumpLong,
   input  logic [N_REQ-1:0] i_req,
   output logic [N_REQ-1:0] o_ack,
   output logic [31:0]      o_data,
   output logic             o_seeded,
   output logic             o_busy
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // Jump polynomials, word 0 in bits [31:0].
   localparam logic [127:0] J_NORM = 128'h77f2db5b_6fa035c3_f542d2d3_8764000b;
   localparam logic [127:0] J_LONG = 128'h1c580662_ccf5a0ef_0b6f099f_b523952e;

   typedef enum logic [1:0] {ST_UNSEEDED, ST_READY, ST_JUMP, ST_JLOAD} state_t;

   state_t           state_q, state_d;
   logic [127:0]     jconst_q, acc_q;
   logic [6:0]       k_q;
   logic [PW-1:0]    rr_ptr_q;
   logic [N_REQ-1:0] ack_q;
   logic [31:0]      data_q;
   logic             seeded_q;

   logic             core_cg, core_seed_vld, seed_from_acc;
   logic [127:0]     core_seed;
   logic [31:0]      core_result, core_s0, core_s1, core_s2, core_s3;

   logic             gnt_en, jump_start, jump_step;
   logic [N_REQ-1:0] req_eff, gnt_oh;
   logic             gnt_found;
   logic [PW-1:0]    gnt_idx, cand;

   assign core_seed = seed_from_acc ? acc_q : i_seed;

   prngXoshiro128pp u_core (
      .i_clk       (i_clk),
      .i_cg        (core_cg),
      .i_seedValid (core_seed_vld),
      .i_seed      (core_seed),
      .o_result    (core_result),
      .o_s0        (core_s0),
      .o_s1        (core_s1),
      .o_s2        (core_s2),
      .o_s3        (core_s3)
   );

   // A requester whose ack is on the bus this cycle has already been served, so it is
   // masked. Without the mask it would win a second word against the same request.
   assign req_eff = i_req & ~ack_q;

   // Round-robin: search begins one past the previous winner.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = PW'((int'(rr_ptr_q) + i) % N_REQ);
         if (!gnt_found && req_eff[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
      for (int j = 0; j < N_REQ; j++) begin
         gnt_oh[j] = gnt_found && (gnt_idx == PW'(j));
      end
   end

   // Next state and core control. Priority: seed > jump > serve.
   always_comb begin
      state_d       = state_q;
      core_cg       = 1'b0;
      core_seed_vld = 1'b0;
      seed_from_acc = 1'b0;
      gnt_en        = 1'b0;
      jump_start    = 1'b0;
      jump_step     = 1'b0;
      case (state_q)
         ST_UNSEEDED: begin
            if (i_seedValid) begin
               core_cg       = 1'b1;
               core_seed_vld = 1'b1;
               state_d       = ST_READY;
            end
         end
         ST_READY: begin
            if (i_seedValid) begin
               core_cg       = 1'b1;
               core_seed_vld = 1'b1;
            end else if (i_jump) begin
               jump_start = 1'b1;
               state_d    = ST_JUMP;
            end else if (gnt_found) begin
               gnt_en  = 1'b1;
               core_cg = 1'b1;
            end
         end
         ST_JUMP: begin
            core_cg = 1'b1;
            if (i_seedValid) begin
               core_seed_vld = 1'b1;
               state_d       = ST_READY;
            end else begin
               jump_step = 1'b1;
               if (k_q == 7'd127) state_d = ST_JLOAD;
            end
         end
         ST_JLOAD: begin
            // A seed from outside takes priority over the accumulated jump state.
            core_cg       = 1'b1;
            core_seed_vld = 1'b1;
            seed_from_acc = !i_seedValid;
            state_d       = ST_READY;
         end
         default: state_d = ST_UNSEEDED;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= ST_UNSEEDED;
         jconst_q <= '0;
         acc_q    <= '0;
         k_q      <= '0;
         rr_ptr_q <= PW'(N_REQ - 1);
         ack_q    <= '0;
         data_q   <= '0;
         seeded_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (core_seed_vld) seeded_q <= 1'b1;
         if (jump_start) begin
            jconst_q <= i_jumpLong ? J_LONG : J_NORM;
            acc_q    <= '0;
            k_q      <= '0;
         end else if (jump_step) begin
            // Fold in the state from before this cycle's step.
            if (jconst_q[k_q]) acc_q <= acc_q ^ {core_s3, core_s2, core_s1, core_s0};
            k_q <= k_q + 7'd1;
         end
         ack_q <= gnt_en ? gnt_oh : '0;
         if (gnt_en) begin
            // Capture the word of the state from before the step.
            data_q   <= core_result;
            rr_ptr_q <= gnt_idx;
         end
      end
   end

   assign o_ack    = ack_q;
   assign o_data   = data_q;
   assign o_seeded = seeded_q;
   assign o_busy   = (state_q == ST_JUMP) || (state_q == ST_JLOAD);
endmodule

// File: tb/tb_prng_xoshiro_arbiter.sv
// Purpose : scoreboard bench for prng_xoshiro_arbiter. It covers seeding, round-robin
//           handout, jump and long jump, jump abort, and reset.
// Latency : expected acks carry the cycle they must appear in.
// Backpr. : stimulus pushes expectations; a negedge monitor pops one per observed ack.
module tb_prng_xoshiro_arbiter;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         seed_vld = 1'b0;
   logic [127:0] seed = '0;
   logic         jump = 1'b0;
   logic         jump_long = 1'b0;
   logic [3:0]   req = '0;
   logic [3:0]   ack;
   logic [31:0]  data;
   logic         seeded, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int          cyc;
      logic [3:0]  ack;
      logic [31:0] dat;
   } exp_t;
   exp_t exp_q[$];

   localparam logic [127:0] JN = 128'h77f2db5b_6fa035c3_f542d2d3_8764000b;
   localparam logic [127:0] JL = 128'h1c580662_ccf5a0ef_0b6f099f_b523952e;

   // Reference xoshiro128++ state.
   logic [31:0] m0, m1, m2, m3;

   prng_xoshiro_arbiter #(.N_REQ(4)) u_dut (
      .i_clk       (clk),
      .i_rst       (rst_n),
      .i_seedValid (seed_vld),
      .i_seed      (seed),
      .i_jump      (jump),
      .i_jumpLong  (jump_long),
      .i_req       (req),
      .o_ack       (ack),
      .o_data      (data),
      .o_seeded    (seeded),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
      return (x << k) | (x >> (32 - k));
   endfunction

   task automatic model_set(input logic [127:0] s);
      {m3, m2, m1, m0} = s;
   endtask

   task automatic model_next(output logic [31:0] r);
      logic [31:0] t;
      r  = rotl(m0 + m3, 7) + m0;
      t  = m1 << 9;
      m2 = m2 ^ m0;
      m3 = m3 ^ m1;
      m1 = m1 ^ m2;
      m0 = m0 ^ m3;
      m2 = m2 ^ t;
      m3 = rotl(m3, 11);
   endtask

   task automatic model_jump(input logic [127:0] jc);
      logic [31:0] a0, a1, a2, a3, dummy;
      a0 = 0; a1 = 0; a2 = 0; a3 = 0;
      for (int b = 0; b < 128; b++) begin
         if (jc[b]) begin
            a0 ^= m0; a1 ^= m1; a2 ^= m2; a3 ^= m3;
         end
         model_next(dummy);
      end
      m0 = a0; m1 = a1; m2 = a2; m3 = a3;
   endtask

   task automatic push(input int c, input logic [3:0] a, input logic [31:0] d);
      exp_t e;
      e.cyc = c; e.ack = a; e.dat = d;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every observed ack must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && ack != 4'b0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack=%b data=%0d expected none (cyc %0d)", ack, data, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack_cycle", 128'(cyc), 128'(e.cyc));
            chk("ack_onehot", 128'(ack), 128'(e.ack));
            chk("ack_data", 128'(data), 128'(e.dat));
         end
      end
   end

   // Jump with requester 0 held: 129 busy cycles, no acks, then the post-jump word.
   task automatic do_jump(input logic lng, input logic [127:0] jc);
      int j;
      int busy_cnt;
      logic [31:0] r;
      logic [127:0] exp_state;
      busy_cnt  = 0;
      j         = cyc;
      jump      = 1'b1;
      jump_long = lng;
      req       = 4'b0001;
      model_jump(jc);
      exp_state = {m3, m2, m1, m0};
      model_next(r);
      push(j + 131, 4'b0001, r);
      tick();
      jump = 1'b0;
      for (int i = 0; i < 140; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (cyc == j + 130)
            chk(lng ? "long_jump_state" : "jump_state",
                {u_dut.u_core.o_s3, u_dut.u_core.o_s2, u_dut.u_core.o_s1, u_dut.u_core.o_s0},
                exp_state);
         if (cyc == j + 131) req = 4'b0000;
      end
      chk(lng ? "long_busy_len" : "busy_len", 128'(busy_cnt), 128'd129);
   endtask

   initial begin
      int s, j;
      logic [31:0] r;

      // Reset values.
      repeat (2) @(negedge clk);
      chk("rst_ack", 128'(ack), 128'd0);
      chk("rst_data", 128'(data), 128'd0);
      chk("rst_seeded", 128'(seeded), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      rst_n = 1'b1;

      // Requests and a jump before any seed are ignored.
      req  = 4'b0001;
      jump = 1'b1;
      tick();
      jump = 1'b0;
      repeat (4) tick();
      chk("unseeded_seeded", 128'(seeded), 128'd0);
      chk("unseeded_busy", 128'(busy), 128'd0);

      // Seed {4,3,2,1}; a single requester is served every other cycle.
      s        = cyc;
      seed     = {32'd4, 32'd3, 32'd2, 32'd1};
      seed_vld = 1'b1;
      model_set(seed);
      model_next(r);
      model_next(r);
      push(s + 2, 4'b0001, 32'd641);
      push(s + 4, 4'b0001, 32'd1573767);
      tick();
      seed_vld = 1'b0;
      chk("seeded_rise", 128'(seeded), 128'd1);
      repeat (3) tick();
      req = 4'b0000;
      repeat (2) tick();

      do_jump(1'b0, JN);
      repeat (2) tick();
      do_jump(1'b1, JL);
      repeat (2) tick();

      // A seed at jump step k=50 aborts the jump.
      j    = cyc;
      jump = 1'b1;
      tick();
      jump = 1'b0;
      repeat (50) tick();
      chk("abort_busy_before", 128'(busy), 128'd1);
      s        = cyc;
      seed     = {32'd4, 32'd3, 32'd2, 32'd1};
      seed_vld = 1'b1;
      req      = 4'b0001;
      model_set(seed);
      model_next(r);
      push(s + 2, 4'b0001, 32'd641);
      tick();
      seed_vld = 1'b0;
      chk("abort_busy_after", 128'(busy), 128'd0);
      chk("abort_state",
          {u_dut.u_core.o_s3, u_dut.u_core.o_s2, u_dut.u_core.o_s1, u_dut.u_core.o_s0},
          {32'd4, 32'd3, 32'd2, 32'd1});
      tick();
      req = 4'b0000;
      repeat (2) tick();

      // Seed and jump in the same cycle: the seed wins and the jump is dropped.
      s        = cyc;
      seed     = {32'd8, 32'd7, 32'd6, 32'd5};
      seed_vld = 1'b1;
      jump     = 1'b1;
      model_set(seed);
      model_next(r);
      push(s + 2, 4'b0001, 32'd1669);
      tick();
      seed_vld = 1'b0;
      jump     = 1'b0;
      req      = 4'b0001;
      chk("seedjump_busy1", 128'(busy), 128'd0);
      tick();
      req = 4'b0000;
      chk("seedjump_busy2", 128'(busy), 128'd0);
      tick();
      chk("seedjump_busy3", 128'(busy), 128'd0);
      repeat (2) tick();

      // Fresh reset, then four requesters: order 0,1,2,3,0, one per cycle.
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      s        = cyc;
      seed     = {32'd4, 32'd3, 32'd2, 32'd1};
      seed_vld = 1'b1;
      req      = 4'b1111;
      model_set(seed);
      for (int i = 0; i < 5; i++) begin
         logic [3:0] oh;
         oh = 4'b0001 << (i % 4);
         model_next(r);
         push(s + 2 + i, oh, r);
      end
      tick();
      seed_vld = 1'b0;
      repeat (5) tick();
      req = 4'b0000;
      repeat (2) tick();

      // Mid-stream reset drops ack and seeded at once.
      s        = cyc;
      seed     = {32'd4, 32'd3, 32'd2, 32'd1};
      seed_vld = 1'b1;
      req      = 4'b1111;
      push(s + 2, 4'b0010, 32'd641);
      push(s + 3, 4'b0100, 32'd1573767);
      tick();
      seed_vld = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_ack", 128'(ack), 128'd0);
      chk("midrst_seeded", 128'(seeded), 128'd0);
      chk("midrst_busy", 128'(busy), 128'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      req = 4'b0000;
      chk("post_reset_seeded", 128'(seeded), 128'd0);
      repeat (2) tick();
      chk("pending_expectations", 128'(exp_q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
